seg_disp_arbiter: RTL and testbench
===================================

SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

Interface
REQ-001 Parameter DWELL, default 32'd5_000_000, SHALL set the minimum hold time in sys_clk cycles after a grant; legal range 1..2^32-1.
REQ-002 Port sys_clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 Port sys_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port req  input  3  SHALL carry level requests, one bit per requester 0..2.
REQ-005 Ports req_data0, req_data1, req_data2  input  24 each  SHALL carry each requester's 6-hex-digit value; bits [7:0] are the lowest digit pair.
REQ-006 Port ack  output  3  SHALL pulse high for one cycle per accepted transfer, one-hot.
REQ-007 Ports data0, data1, data2  output  8 each  SHALL feed the hex display driver: data0 = value[7:0], data1 = value[15:8], data2 = value[23:16].
REQ-008 Port owner  output  2  SHALL give the current display owner 0..2; 3 means no owner since reset.
REQ-009 Port busy  output  1  SHALL be high while in HOLD.

Function
REQ-010 The block SHALL implement two states, IDLE and HOLD, with all outputs registered.
REQ-011 In IDLE, with req != 0 at a rising edge, that edge SHALL select the winner by round-robin.
REQ-012 On that grant edge, the block SHALL latch the winner's req_dataN into data0..2, set ack[winner]=1, set owner=winner, clear dwell_cnt to 0, and enter HOLD.
REQ-013 Grant latency SHALL be one edge: ack and the new data are visible in the cycle after req is sampled high.
REQ-014 Round-robin priority SHALL start at (owner+1) mod 3 and wrap 2->0; owner=3 gives priority order 0,1,2.
REQ-015 In IDLE with req == 0, the block SHALL hold data0..2 and owner unchanged and keep ack=0.
REQ-016 In HOLD, dwell_cnt SHALL increment by 1 per cycle.
REQ-017 When dwell_cnt == DWELL-1, the block SHALL enter IDLE on that edge, and arbitration SHALL occur no earlier than the following edge.
- HOLD lasts exactly DWELL cycles.
- The minimum grant-to-grant spacing is DWELL+1 cycles.
REQ-018 In HOLD, when not on the expiry edge and req[owner]=1, the block SHALL perform a refresh:
- latch req_data[owner] into data0..2;
- pulse ack[owner];
- leave dwell_cnt, owner and state unchanged.
REQ-019 In HOLD, requests from non-owners SHALL be ignored, with no ack; they remain pending as levels.
REQ-020 On the expiry edge, expiry SHALL take precedence over refresh: no ack, and the owner competes at lowest priority at the next arbitration.
REQ-021 A requester holding req high SHALL be accepted again on every eligible edge; requesters deassert req after seeing ack, and this is not an error.
REQ-022 At most one ack bit SHALL be high in any cycle.
REQ-023 busy SHALL equal (state == HOLD).
REQ-024 dwell_cnt SHALL be 32 bits and SHALL never wrap, since expiry resets the state before overflow.
REQ-025 DWELL=1 SHALL give a one-cycle HOLD with no refresh opportunity.

Reset
REQ-026 On sys_rst_n low, the block SHALL immediately force state=IDLE, data0..2=8'h00, ack=3'b000, owner=2'd3, busy=0 and dwell_cnt=0, including during HOLD.
REQ-027 After reset release, the first arbitration SHALL occur on the first rising edge with sys_rst_n high.
REQ-028 No ack SHALL be issued for a request sampled while reset was asserted.

Verification (DWELL=4)
REQ-029 Scenario: after reset, sample outputs -> data0..2=00, owner=3, busy=0, ack=000.
REQ-030 Scenario: req=3'b111 held, data0=24'h123456, data1=24'hABCDEF, data2=24'h000F0F.
- Grants SHALL occur in order 0,1,2,0 spaced 5 cycles apart.
- On grant 0: data2/1/0 = 12/34/56.
- On grant 1: data2/1/0 = AB/CD/EF.
- On each grant the one-hot ack matches owner.
REQ-031 Scenario: owner 1 in HOLD, req[1] pulses with data1=24'h00BEEF at dwell_cnt=1.
- data0=EF, data1=BE, data2=00, and ack=3'b010, on the next cycle.
- HOLD still ends 4 cycles after the original grant.
REQ-032 Scenario: req[2] asserted during owner 0's HOLD -> ack[2] is not issued until 1 cycle after expiry; busy shows 1,1,1,1,0,1.
REQ-033 Scenario: sys_rst_n pulsed low mid-HOLD with owner=2 -> outputs return to reset values asynchronously, and the next grant goes to requester 0 if req=3'b101.
REQ-034 Scenario: owner 2 in HOLD with req[2] high on the expiry edge -> no ack on that edge; req=3'b100 alone -> re-granted to 2 one cycle later.

Source files
------------

// File: rtl/seg_disp_arbiter_if.sv
// Request/display bundle between three display requesters and seg_disp_arbiter.
// The requester side drives levels and values; the arbiter drives the latched display value.
interface seg_disp_arbiter_if;
    logic [2:0]  req;
    logic [23:0] req_data0;
    logic [23:0] req_data1;
    logic [23:0] req_data2;
    logic [2:0]  ack;
    logic [7:0]  data0;
    logic [7:0]  data1;
    logic [7:0]  data2;
    logic [1:0]  owner;
    logic        busy;

    modport master (
        output req,
        output req_data0,
        output req_data1,
        output req_data2,
        input  ack,
        input  data0,
        input  data1,
        input  data2,
        input  owner,
        input  busy
    );

    modport slave (
        input  req,
        input  req_data0,
        input  req_data1,
        input  req_data2,
        output ack,
        output data0,
        output data1,
        output data2,
        output owner,
        output busy
    );
endinterface

// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter that hands a 6-digit hex display to one of three requesters
// and holds ownership for DWELL cycles, allowing the owner to refresh its value meanwhile.
module seg_disp_arbiter #(
    parameter logic [31:0] DWELL = 32'd5_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    seg_disp_arbiter_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;
    localparam logic [1:0] NO_OWNER = 2'd3;

    logic [0:0]  state_reg;
    logic [0:0]  state_next;
    logic [31:0] dwell_cnt_reg;
    logic [31:0] dwell_cnt_next;
    logic [1:0]  owner_reg;
    logic [1:0]  owner_next;
    logic [2:0]  ack_reg;
    logic [2:0]  ack_next;
    logic [23:0] value_reg;
    logic [23:0] value_next;

    // Index 3 is a dummy slot so a 2-bit owner code can address the tables directly.
    logic [23:0] req_data_arr [4];
    logic [3:0]  req_ext;

    logic [1:0]  rr_start;
    logic [1:0]  cand_idx [3];
    logic [2:0]  cand_req;
    logic [1:0]  winner;
    logic        any_req;
    logic        owner_req;
    logic        dwell_expire;
    logic        ack_fire;
    logic [1:0]  ack_sel;

    assign req_ext = {1'b0, bus.req};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req_data
            if (gi == 0) begin : g_d0
                assign req_data_arr[gi] = bus.req_data0;
            end else if (gi == 1) begin : g_d1
                assign req_data_arr[gi] = bus.req_data1;
            end else if (gi == 2) begin : g_d2
                assign req_data_arr[gi] = bus.req_data2;
            end else begin : g_dnone
                assign req_data_arr[gi] = 24'h00_0000;
            end
        end
    endgenerate

    // Search starts just past the current owner, so the last owner ranks lowest.
    always_comb begin
        rr_start = 2'd0;
        if (owner_reg < 2'd2) begin
            rr_start = owner_reg + 2'd1;
        end
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_cand
            logic [2:0] sum;
            assign sum          = {1'b0, rr_start} + 3'(gi);
            assign cand_idx[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            assign cand_req[gi] = req_ext[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = cand_idx[2];
        if (cand_req[0]) begin
            winner = cand_idx[0];
        end else if (cand_req[1]) begin
            winner = cand_idx[1];
        end
    end

    assign any_req      = |bus.req;
    assign owner_req    = req_ext[owner_reg];
    assign dwell_expire = (dwell_cnt_reg == (DWELL - 32'd1));

    always_comb begin
        state_next     = state_reg;
        dwell_cnt_next = dwell_cnt_reg;
        owner_next     = owner_reg;
        value_next     = value_reg;
        ack_fire       = 1'b0;
        ack_sel        = 2'd0;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    ack_fire       = 1'b1;
                    ack_sel        = winner;
                    value_next     = req_data_arr[winner];
                    owner_next     = winner;
                    dwell_cnt_next = 32'd0;
                    state_next     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Expiry wins over a simultaneous refresh from the owner.
                if (dwell_expire) begin
                    state_next     = ST_IDLE;
                    dwell_cnt_next = 32'd0;
                end else begin
                    dwell_cnt_next = dwell_cnt_reg + 32'd1;
                    if (owner_req) begin
                        ack_fire   = 1'b1;
                        ack_sel    = owner_reg;
                        value_next = req_data_arr[owner_reg];
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_ack
            assign ack_next[gi] = ack_fire && (ack_sel == 2'(gi));
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= ST_IDLE;
            dwell_cnt_reg <= 32'd0;
            owner_reg     <= NO_OWNER;
            ack_reg       <= 3'b000;
            value_reg     <= 24'h00_0000;
        end else begin
            state_reg     <= state_next;
            dwell_cnt_reg <= dwell_cnt_next;
            owner_reg     <= owner_next;
            ack_reg       <= ack_next;
            value_reg     <= value_next;
        end
    end

    assign bus.ack   = ack_reg;
    assign bus.data0 = value_reg[7:0];
    assign bus.data1 = value_reg[15:8];
    assign bus.data2 = value_reg[23:16];
    assign bus.owner = owner_reg;
    assign bus.busy  = (state_reg == ST_HOLD);

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Bench for seg_disp_arbiter: a DWELL=4 and a DWELL=1 instance share stimulus and are
// checked every cycle against a hold-countdown model plus directed literal expectations.
module tb_seg_disp_arbiter;

    localparam int DW [2] = '{4, 1};

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [2:0]  req;
    logic [23:0] rd0, rd1, rd2;

    int n_checks = 0;
    int n_fail   = 0;

    seg_disp_arbiter_if if_a ();
    seg_disp_arbiter_if if_b ();

    assign if_a.req = req;  assign if_a.req_data0 = rd0;
    assign if_a.req_data1 = rd1; assign if_a.req_data2 = rd2;
    assign if_b.req = req;  assign if_b.req_data0 = rd0;
    assign if_b.req_data1 = rd1; assign if_b.req_data2 = rd2;

    seg_disp_arbiter #(.DWELL(32'd4)) dut_a (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_a));
    seg_disp_arbiter #(.DWELL(32'd1)) dut_b (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_b));

    always #5 sys_clk = ~sys_clk;

    logic [2:0] ack_w [2];
    logic [1:0] own_w [2];
    logic       busy_w [2];
    logic [23:0] val_w [2];
    assign ack_w[0] = if_a.ack;   assign ack_w[1] = if_b.ack;
    assign own_w[0] = if_a.owner; assign own_w[1] = if_b.owner;
    assign busy_w[0] = if_a.busy; assign busy_w[1] = if_b.busy;
    assign val_w[0] = {if_a.data2, if_a.data1, if_a.data0};
    assign val_w[1] = {if_b.data2, if_b.data1, if_b.data0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining hold cycles per instance; 0 means free to arbitrate.
    int          m_hold  [2];
    logic [1:0]  m_owner [2];
    logic [2:0]  m_ack   [2];
    logic [23:0] m_val   [2];

    function automatic int pick(input logic [2:0] r, input logic [1:0] own);
        int start = (own == 2'd3) ? 0 : (int'(own) + 1) % 3;
        for (int k = 0; k < 3; k++) begin
            if (r[(start + k) % 3]) return (start + k) % 3;
        end
        return 0;
    endfunction

    function automatic logic [23:0] rd_of(input int n);
        return (n == 0) ? rd0 : (n == 1) ? rd1 : rd2;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_hold[i] <= 0; m_owner[i] <= 2'd3; m_ack[i] <= 3'b000; m_val[i] <= 24'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_ack[i] <= 3'b000;
                if (m_hold[i] > 0) begin
                    if (m_hold[i] == 1) begin
                        m_hold[i] <= 0;
                    end else begin
                        m_hold[i] <= m_hold[i] - 1;
                        if (req[m_owner[i]]) begin
                            m_val[i] <= rd_of(int'(m_owner[i]));
                            m_ack[i] <= 3'b001 << m_owner[i];
                        end
                    end
                end else if (req != 3'b000) begin
                    m_owner[i] <= 2'(pick(req, m_owner[i]));
                    m_val[i]   <= rd_of(pick(req, m_owner[i]));
                    m_ack[i]   <= 3'b001 << pick(req, m_owner[i]);
                    m_hold[i]  <= DW[i];
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_ack%0d", i), 32'(ack_w[i]), 32'(m_ack[i]));
            chk($sformatf("model_owner%0d", i), 32'(own_w[i]), 32'(m_owner[i]));
            chk($sformatf("model_busy%0d", i), 32'(busy_w[i]), 32'(m_hold[i] > 0));
            chk($sformatf("model_data%0d", i), 32'(val_w[i]), 32'(m_val[i]));
            if (ack_w[i] != 3'b000)
                $display("dut%0d ack=%b owner=%0d data=%h busy=%b t=%0t",
                         i, ack_w[i], own_w[i], val_w[i], busy_w[i], $time);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic chk_a(input string tag, input logic [2:0] ack, input logic [1:0] own,
                         input logic busy, input logic [23:0] val);
        chk({tag, "_ack"}, 32'(if_a.ack), 32'(ack));
        chk({tag, "_owner"}, 32'(if_a.owner), 32'(own));
        chk({tag, "_busy"}, 32'(if_a.busy), 32'(busy));
        chk({tag, "_data"}, 32'({if_a.data2, if_a.data1, if_a.data0}), 32'(val));
    endtask

    // Four cycles after a grant with the owner's request still high: three refreshes, then expiry.
    task automatic hold_trace(input string tag, input logic [2:0] oh);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk($sformatf("%s_busy%0d", tag, k), 32'(if_a.busy), 32'(k < 4));
            chk($sformatf("%s_ack%0d", tag, k), 32'(if_a.ack), 32'((k < 4) ? oh : 3'b000));
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        req = 3'b000; rd0 = 24'h0; rd1 = 24'h0; rd2 = 24'h0;
        step(3);
        chk_a("reset", 3'b000, 2'd3, 1'b0, 24'h000000);

        // Round robin with all three requesting continuously.
        sys_rst_n = 1'b1;
        req = 3'b111; rd0 = 24'h123456; rd1 = 24'hABCDEF; rd2 = 24'h000F0F;
        step(1);
        chk_a("rr_g0", 3'b001, 2'd0, 1'b1, 24'h123456);
        chk("b_g0_owner", 32'(if_b.owner), 32'd0);
        step(1);
        chk("b_expire_busy", 32'(if_b.busy), 32'd0);
        step(1);
        chk("b_g1_ack", 32'(if_b.ack), 32'b010);
        step(2);
        chk("a_expire_busy", 32'(if_a.busy), 32'd0);
        chk("a_expire_ack", 32'(if_a.ack), 32'b000);
        step(1);
        chk_a("rr_g1", 3'b010, 2'd1, 1'b1, 24'hABCDEF);
        hold_trace("rr_h1", 3'b010);
        step(1);
        chk_a("rr_g2", 3'b100, 2'd2, 1'b1, 24'h000F0F);
        hold_trace("rr_h2", 3'b100);
        step(1);
        chk_a("rr_g3", 3'b001, 2'd0, 1'b1, 24'h123456);
        req = 3'b000;
        step(3);
        chk("idle_wait_busy", 32'(if_a.busy), 32'd1);
        step(1);
        chk_a("idle_hold", 3'b000, 2'd0, 1'b0, 24'h123456);

        // Owner refresh in the middle of HOLD.
        rd1 = 24'h111111; req = 3'b010;
        step(1);
        chk_a("ref_grant", 3'b010, 2'd1, 1'b1, 24'h111111);
        req = 3'b000;
        step(1);
        req = 3'b010; rd1 = 24'h00BEEF;
        step(1);
        chk_a("ref_upd", 3'b010, 2'd1, 1'b1, 24'h00BEEF);
        req = 3'b000;
        step(1);
        chk("ref_busy3", 32'(if_a.busy), 32'd1);
        step(1);
        chk("ref_end_busy", 32'(if_a.busy), 32'd0);

        // Non-owner request waits for expiry.
        req = 3'b001;
        step(1);
        chk_a("wait_g0", 3'b001, 2'd0, 1'b1, 24'h123456);
        req = 3'b100;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk($sformatf("wait_busy%0d", k), 32'(if_a.busy), 32'(k < 4));
            chk($sformatf("wait_ack%0d", k), 32'(if_a.ack), 32'd0);
        end
        step(1);
        chk_a("wait_g2", 3'b100, 2'd2, 1'b1, 24'h000F0F);

        // Owner 2 keeps requesting through expiry, then is granted again.
        hold_trace("exp_h2", 3'b100);
        step(1);
        chk_a("exp_regrant", 3'b100, 2'd2, 1'b1, 24'h000F0F);

        // Asynchronous reset mid-HOLD.
        step(1);
        sys_rst_n = 1'b0;
        #1;
        chk_a("arst", 3'b000, 2'd3, 1'b0, 24'h000000);
        req = 3'b101;
        step(1);
        chk_a("arst_held", 3'b000, 2'd3, 1'b0, 24'h000000);
        sys_rst_n = 1'b1;
        step(1);
        chk_a("arst_g0", 3'b001, 2'd0, 1'b1, 24'h123456);
        req = 3'b000;
        step(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
